dmem_stream_loader: RTL and testbench

Controller that sequences host AXI-Stream bulk transfers into the GPU data memory write port. Software arms a transfer with a base address and word limit. The block accepts stream beats, buffers them in a 2-entry skid FIFO and issues one memory word write per beat, honouring backpressure from the memory-port arbiter. It sits between the host AXI-Stream interface and the data-memory arbiter inside the gpu top, with config and status routed to the IO register block.

---
 rtl/dmem_stream_loader_pkg.sv | 16 +
 rtl/dmem_stream_loader_skid_fifo.sv | 72 +++++++
 rtl/dmem_stream_loader.sv | 165 ++++++++++++++++
 tb/tb_dmem_stream_loader.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_stream_loader_pkg.sv
// Shared definitions for the data-memory stream loader and the data-memory
// arbiter: loader state encoding, the full-word byte-enable pattern and the
// default word-address width.
package dmem_stream_loader_pkg;

    localparam int         ADDR_W_DEF = 12;
    localparam logic [3:0] WR_EN_FULL = 4'hF;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_DRAIN = 2'd2,
        LD_DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/dmem_stream_loader_skid_fifo.sv
// stream_skid_fifo: 2-entry FIFO with registered empty flag.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         empties the FIFO (wins over push/pop)
//   push/push_data write one word (ignored when full unless popping)
//   pop           remove head word (ignored when empty)
//   head_data     current head word, valid while !empty
//   empty         registered empty flag
//   full_nxt      fullness the FIFO will have after this cycle
module stream_skid_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full_nxt
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_nxt;
    logic              empty_q;
    logic              full_q;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is legal only when the head leaves the same cycle.
    always_comb begin
        do_push  = push && (!full_q || pop);
        do_pop   = pop && !empty_q;
        cnt_nxt  = flush ? 2'd0 : (cnt_q + {1'b0, do_push} - {1'b0, do_pop});
        full_nxt = (cnt_nxt == 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            cnt_q   <= cnt_nxt;
            empty_q <= (cnt_nxt == 2'd0);
            full_q  <= full_nxt;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = empty_q;

endmodule

// File: rtl/dmem_stream_loader.sv
// dmem_stream_loader: moves host AXI-Stream bulk transfers into the data-memory
// write port. Software arms a transfer (base address, word limit); each kept
// beat is buffered in a 2-entry skid FIFO and written as one memory word.
// Ports:
//   axis_clk, axis_aresetn              clock, asynchronous active-low reset
//   cfg_start/cfg_abort                 arm / abort pulses
//   cfg_base_addr, cfg_max_words        transfer setup, latched on start
//   axis_tdata/tkeep/tlast/tvalid/tready stream slave
//   mem_addr/mem_wr_data/mem_wr_en      memory write request
//   mem_wr_ready                        arbiter grant
//   status_busy/done/overflow/word_count transfer status
module dmem_stream_loader
    import dmem_stream_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = 32
) (
    input  logic              axis_clk,
    input  logic              axis_aresetn,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ADDR_W:0]   cfg_max_words,
    input  logic [DATA_W-1:0] axis_tdata,
    input  logic              axis_tkeep,
    input  logic              axis_tlast,
    input  logic              axis_tvalid,
    output logic              axis_tready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [3:0]        mem_wr_en,
    input  logic              mem_wr_ready,
    output logic              status_busy,
    output logic              status_done,
    output logic              status_overflow,
    output logic [ADDR_W:0]   status_word_count
);

    loader_state_t     state_q;
    logic              tready_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   max_q;
    logic [ADDR_W:0]   acc_cnt_q;
    logic [ADDR_W:0]   word_cnt_q;

    logic              start_ok;
    logic              abort_ok;
    logic              beat_acc;
    logic              room;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full_nxt;
    logic [DATA_W-1:0] fifo_head;

    // tready_q is only ever high in LOAD, so it also qualifies the state.
    always_comb begin
        start_ok  = cfg_start && (state_q == LD_IDLE);
        abort_ok  = cfg_abort && ((state_q == LD_LOAD) || (state_q == LD_DRAIN));
        beat_acc  = axis_tvalid && tready_q && !abort_ok;
        room      = (acc_cnt_q < max_q);
        fifo_push = beat_acc && axis_tkeep && room;
        fifo_pop  = !fifo_empty && mem_wr_ready;
    end

    stream_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (axis_clk),
        .rst_n     (axis_aresetn),
        .flush     (abort_ok),
        .push      (fifo_push),
        .push_data (axis_tdata),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full_nxt  (fifo_full_nxt)
    );

    always_ff @(posedge axis_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q    <= LD_IDLE;
            tready_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            base_q     <= '0;
            max_q      <= '0;
            acc_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                LD_IDLE: begin
                    // The FIFO is always empty here, so tready can open at once.
                    if (cfg_start) begin
                        state_q  <= LD_LOAD;
                        busy_q   <= 1'b1;
                        tready_q <= 1'b1;
                    end
                end
                LD_LOAD: begin
                    if (abort_ok) begin
                        state_q  <= LD_IDLE;
                        busy_q   <= 1'b0;
                        tready_q <= 1'b0;
                    end else if (beat_acc && axis_tlast) begin
                        state_q  <= LD_DRAIN;
                        tready_q <= 1'b0;
                    end else begin
                        tready_q <= !fifo_full_nxt;
                    end
                end
                LD_DRAIN: begin
                    if (abort_ok) begin
                        state_q <= LD_IDLE;
                        busy_q  <= 1'b0;
                    end else if (fifo_empty) begin
                        state_q <= LD_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                LD_DONE: begin
                    state_q <= LD_IDLE;
                end
                default: begin
                    state_q  <= LD_IDLE;
                    busy_q   <= 1'b0;
                    tready_q <= 1'b0;
                end
            endcase

            if (start_ok) begin
                base_q     <= cfg_base_addr;
                max_q      <= cfg_max_words;
                acc_cnt_q  <= '0;
                word_cnt_q <= '0;
                ovf_q      <= 1'b0;
            end else begin
                // A write retiring in the abort cycle still counts as written.
                if (fifo_pop)  word_cnt_q <= word_cnt_q + (ADDR_W+1)'(1);
                if (fifo_push) acc_cnt_q  <= acc_cnt_q + (ADDR_W+1)'(1);
                if (beat_acc && axis_tkeep && !room) ovf_q <= 1'b1;
            end
        end
    end

    // Write request is driven straight from the FIFO head; the address only
    // advances on retire, so a stalled request holds steady. Truncating the
    // count to ADDR_W bits gives the silent address wrap.
    assign mem_wr_en   = fifo_empty ? 4'h0 : WR_EN_FULL;
    assign mem_wr_data = fifo_empty ? '0 : fifo_head;
    assign mem_addr    = fifo_empty ? '0 : (base_q + word_cnt_q[ADDR_W-1:0]);

    assign axis_tready       = tready_q;
    assign status_busy       = busy_q;
    assign status_done       = done_q;
    assign status_overflow   = ovf_q;
    assign status_word_count = word_cnt_q;

endmodule

// File: tb/tb_dmem_stream_loader.sv
module tb_dmem_stream_loader;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              axis_clk = 1'b0;
    logic              axis_aresetn = 1'b0;
    logic              cfg_start = 1'b0;
    logic              cfg_abort = 1'b0;
    logic [ADDR_W-1:0] cfg_base_addr = '0;
    logic [ADDR_W:0]   cfg_max_words = '0;
    logic [DATA_W-1:0] axis_tdata = '0;
    logic              axis_tkeep = 1'b0;
    logic              axis_tlast = 1'b0;
    logic              axis_tvalid = 1'b0;
    logic              axis_tready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [3:0]        mem_wr_en;
    logic              mem_wr_ready = 1'b0;
    logic              status_busy;
    logic              status_done;
    logic              status_overflow;
    logic [ADDR_W:0]   status_word_count;

    always #5 axis_clk = ~axis_clk;

    dmem_stream_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .axis_clk          (axis_clk),
        .axis_aresetn      (axis_aresetn),
        .cfg_start         (cfg_start),
        .cfg_abort         (cfg_abort),
        .cfg_base_addr     (cfg_base_addr),
        .cfg_max_words     (cfg_max_words),
        .axis_tdata        (axis_tdata),
        .axis_tkeep        (axis_tkeep),
        .axis_tlast        (axis_tlast),
        .axis_tvalid       (axis_tvalid),
        .axis_tready       (axis_tready),
        .mem_addr          (mem_addr),
        .mem_wr_data       (mem_wr_data),
        .mem_wr_en         (mem_wr_en),
        .mem_wr_ready      (mem_wr_ready),
        .status_busy       (status_busy),
        .status_done       (status_done),
        .status_overflow   (status_overflow),
        .status_word_count (status_word_count)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: whether a transfer is accepting beats, how many
    // words the loader should be holding, and the words seen leaving it.
    int                cyc = 0;
    bit                loading = 1'b0;
    int                occ = 0;
    int                kept_cnt = 0;
    int                cur_max = 0;
    bit                last_acc = 1'b0;
    bit                prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [ADDR_W-1:0] got_addr[$];
    logic [DATA_W-1:0] got_data[$];
    int                done_cnt = 0;
    int                first_acc = -1;
    int                first_wr = -1;
    bit                saw_tready_low = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic ready_val(input int rmode);
        case (rmode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 1;
            2:       return $urandom_range(0, 9) < 7;
            default: return 1'b0;
        endcase
    endfunction

    task automatic sample_cycle();
        bit wr;
        bit retire;
        check("tready", axis_tready, loading && (occ < 2));
        wr = (mem_wr_en != 4'h0);
        if (wr) check("wr_en_value", mem_wr_en, 4'hF);
        if (prev_stall) begin
            check("stall_en", wr, 1'b1);
            check("stall_addr", mem_addr, prev_addr);
            check("stall_data", mem_wr_data, prev_data);
        end
        retire = wr && mem_wr_ready;
        if (wr && first_wr < 0) first_wr = cyc;
        if (retire) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wr_data);
        end
        prev_stall = wr && !mem_wr_ready;
        prev_addr  = mem_addr;
        prev_data  = mem_wr_data;
        if (status_done) done_cnt++;
        if (loading && !axis_tready) saw_tready_low = 1'b1;
        last_acc = axis_tvalid && axis_tready;
        if (last_acc) begin
            if (first_acc < 0) first_acc = cyc;
            if (axis_tkeep && kept_cnt < cur_max) begin
                occ++;
                kept_cnt++;
            end
            if (axis_tlast) loading = 1'b0;
        end
        if (retire) occ--;
        if (cfg_abort && status_busy) begin
            loading    = 1'b0;
            occ        = 0;
            prev_stall = 1'b0;
        end
        if (cfg_start && !status_busy && !status_done) begin
            loading  = 1'b1;
            occ      = 0;
            kept_cnt = 0;
            cur_max  = int'(cfg_max_words);
        end
    endtask

    task automatic tick();
        @(negedge axis_clk);
        sample_cycle();
        @(posedge axis_clk);
        #1;
        cyc++;
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_tready"}, axis_tready, 1'b0);
        check({pfx, "_wr_en"}, mem_wr_en, 4'h0);
        check({pfx, "_addr"}, mem_addr, '0);
        check({pfx, "_wdata"}, mem_wr_data, '0);
        check({pfx, "_busy"}, status_busy, 1'b0);
        check({pfx, "_done"}, status_done, 1'b0);
        check({pfx, "_ovf"}, status_overflow, 1'b0);
        check({pfx, "_wcount"}, status_word_count, '0);
    endtask

    task automatic run_transfer(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] maxw,
                                input int n, input logic [7:0] kmask, input int rmode,
                                output int latency);
        logic [DATA_W-1:0] d[8];
        logic [ADDR_W-1:0] exp_addr[$];
        logic [DATA_W-1:0] exp_data[$];
        int kept;
        bit ovf_exp;
        int budget;
        int i;
        kept    = 0;
        ovf_exp = 1'b0;
        for (int k = 0; k < n; k++) begin
            d[k] = $urandom;
            if (kmask[k]) begin
                if (kept < int'(maxw)) begin
                    exp_addr.push_back(base + ADDR_W'(kept));
                    exp_data.push_back(d[k]);
                    kept++;
                end else begin
                    ovf_exp = 1'b1;
                end
            end
        end
        got_addr.delete();
        got_data.delete();
        done_cnt       = 0;
        first_acc      = -1;
        first_wr       = -1;
        saw_tready_low = 1'b0;

        cfg_base_addr = base;
        cfg_max_words = maxw;
        cfg_start     = 1'b1;
        mem_wr_ready  = ready_val(rmode);
        tick();
        cfg_start = 1'b0;
        check("busy_after_start", status_busy, 1'b1);
        check("ovf_cleared", status_overflow, 1'b0);
        check("wcount_cleared", status_word_count, '0);

        i           = 0;
        budget      = 200;
        axis_tvalid = 1'b0;
        while (i < n && budget > 0) begin
            if (!axis_tvalid) axis_tvalid = (rmode <= 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            axis_tdata   = d[i];
            axis_tkeep   = kmask[i];
            axis_tlast   = (i == n - 1);
            mem_wr_ready = ready_val(rmode);
            tick();
            budget--;
            if (last_acc) begin
                i++;
                axis_tvalid = 1'b0;
            end
        end
        axis_tvalid = 1'b0;
        axis_tkeep  = 1'b0;
        axis_tlast  = 1'b0;
        while (done_cnt == 0 && budget > 0) begin
            mem_wr_ready = ready_val(rmode);
            tick();
            budget--;
        end
        check("done_within_budget", budget > 0, 1'b1);
        mem_wr_ready = 1'b0;
        tick();
        tick();

        check("n_writes", got_addr.size(), exp_addr.size());
        for (int k = 0; k < got_addr.size() && k < exp_addr.size(); k++) begin
            check("wr_addr", got_addr[k], exp_addr[k]);
            check("wr_data", got_data[k], exp_data[k]);
        end
        check("done_pulses", done_cnt, 1);
        check("overflow", status_overflow, ovf_exp);
        check("word_count", status_word_count, exp_addr.size());
        check("idle_busy", status_busy, 1'b0);
        latency = first_wr - first_acc;
    endtask

    task automatic feed_two_beats();
        int k;
        int budget;
        k           = 0;
        budget      = 20;
        axis_tvalid = 1'b1;
        axis_tkeep  = 1'b1;
        axis_tlast  = 1'b0;
        while (k < 2 && budget > 0) begin
            axis_tdata = $urandom;
            tick();
            budget--;
            if (last_acc) k++;
        end
        axis_tvalid = 1'b0;
        axis_tkeep  = 1'b0;
        check("two_beats_accepted", k, 2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        #12;
        check_outputs_zero("reset");
        @(posedge axis_clk);
        #1;
        axis_aresetn = 1'b1;
        tick();
        tick();

        // Basic transfer, back-to-back beats, memory always ready.
        run_transfer(12'h100, 13'd4, 4, 8'h0F, 0, lat);
        check("first_write_latency", lat, 1);

        // Memory grant toggling every cycle.
        run_transfer(12'h100, 13'd4, 4, 8'h0F, 1, lat);
        check("bp_tready_dropped", saw_tready_low, 1'b1);

        // Five data beats against a limit of two.
        run_transfer(12'h200, 13'd2, 5, 8'h1F, 2, lat);

        // Address wrap with a null beat in the middle.
        run_transfer(12'hFFE, 13'd4, 4, 8'h0D, 2, lat);

        // Zero limit: everything discarded, done still pulses.
        run_transfer(12'h010, 13'd0, 3, 8'h07, 2, lat);

        for (int t = 0; t < 10; t++) begin
            run_transfer(ADDR_W'($urandom), 13'($urandom_range(0, 6)),
                         int'($urandom_range(1, 8)), 8'($urandom), 2, lat);
        end

        // Abort in LOAD with two words stuck behind a stalled arbiter.
        done_cnt      = 0;
        cfg_base_addr = 12'h345;
        cfg_max_words = 13'd8;
        cfg_start     = 1'b1;
        mem_wr_ready  = 1'b0;
        tick();
        cfg_start = 1'b0;
        feed_two_beats();
        check("abort_pre_wr_en", mem_wr_en, 4'hF);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("abort_wr_en", mem_wr_en, 4'h0);
        check("abort_busy", status_busy, 1'b0);
        check("abort_tready", axis_tready, 1'b0);
        tick();
        tick();
        tick();
        check("abort_no_done", done_cnt, 0);
        check("abort_wcount", status_word_count, '0);

        // Start and abort together in IDLE: start wins.
        cfg_max_words = 13'd3;
        cfg_start     = 1'b1;
        cfg_abort     = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        check("start_wins_busy", status_busy, 1'b1);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("abort_from_load_busy", status_busy, 1'b0);
        tick();

        // Reset in the middle of LOAD with a pending write and overflow set.
        done_cnt      = 0;
        cfg_base_addr = 12'h0AB;
        cfg_max_words = 13'd1;
        cfg_start     = 1'b1;
        tick();
        cfg_start = 1'b0;
        feed_two_beats();
        check("pre_rst_ovf", status_overflow, 1'b1);
        check("pre_rst_wr_en", mem_wr_en, 4'hF);
        axis_aresetn = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        loading    = 1'b0;
        occ        = 0;
        prev_stall = 1'b0;
        @(posedge axis_clk);
        #1;
        axis_aresetn = 1'b1;
        cyc++;
        tick();
        tick();
        check("rst_no_done", done_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
